// File: rtl/spio_pkg.sv
// Shared types and field-layout helpers for the serial/parallel output port.
// Offsets are derived from the counter_set and LED widths; GPIO sits above both.
package spio_pkg;

    localparam int DATA_W       = 32;
    localparam int DEF_CS_BITS  = 2;
    localparam int DEF_LED_BITS = 16;
    localparam int DEF_LED_LO   = DEF_CS_BITS;
    localparam int DEF_GPIO_LO  = DEF_CS_BITS + DEF_LED_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    function automatic int led_lo(input int cs_bits);
        return cs_bits;
    endfunction

    function automatic int gpio_lo(input int cs_bits, input int led_bits);
        return cs_bits + led_bits;
    endfunction

endpackage

// File: rtl/spio_gen_if.sv
// CPU-side register bus and frame handshake of the output port.
// The CPU is the master; the port block is the slave.
interface spio_gen_if;
    import spio_pkg::*;

    logic              wr_en;
    logic [3:0]        wr_be;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              auto_en;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_be, wr_data, start, auto_en,
        input  rd_data, busy, done
    );

    modport slave (
        input  wr_en, wr_be, wr_data, start, auto_en,
        output rd_data, busy, done
    );

endinterface

// File: rtl/led_p2s_gen.sv
// Parallel-to-serial LED chain engine: LOAD(1) + SHIFT(2*CLK_DIV*LED_BITS) + LATCH(CLK_DIV) + DONE(1) cycles.
// No backpressure: kick is sampled only in IDLE and DONE; all outputs are registered.
module led_p2s_gen
    import spio_pkg::*;
#(
    parameter int LED_BITS  = 16,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kick,
    input  logic [LED_BITS-1:0] data,
    output state_t              state,
    output logic                busy,
    output logic                done,
    output logic                led_clk,
    output logic                led_sout,
    output logic                led_pen
);

    localparam int CW = $clog2(LED_BITS);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [LED_BITS-1:0] sreg;
    logic [CW-1:0]       bit_cnt;
    logic [DW-1:0]       div_cnt;

    function automatic logic [LED_BITS-1:0] adv(input logic [LED_BITS-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic head(input logic [LED_BITS-1:0] v);
        return (MSB_FIRST != 0) ? v[LED_BITS-1] : v[0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            led_clk  <= 1'b0;
            led_sout <= 1'b0;
            led_pen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (kick) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // First bit is presented here so it is stable for the whole low phase.
                    sreg     <= data;
                    led_sout <= head(data);
                    led_clk  <= 1'b0;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!led_clk) begin
                            led_clk <= 1'b1;
                        end else begin
                            led_clk <= 1'b0;
                            if (bit_cnt == CW'(LED_BITS - 1)) begin
                                led_pen <= 1'b1;
                                state   <= ST_LATCH;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                sreg     <= adv(sreg);
                                led_sout <= head(adv(sreg));
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        led_pen <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (kick) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/spio_gen.sv
// Memory-mapped {gpio, led, counter_set} output word with byte-lane writes and LED chain refresh.
// Refresh latency one frame; triggers arriving during a frame coalesce into a single follow-up frame.
module spio_gen
    import spio_pkg::*;
#(
    parameter int          LED_BITS  = 16,
    parameter int          CS_BITS   = 2,
    parameter int          GPIO_BITS = 14,
    parameter int          CLK_DIV   = 2,
    parameter int          MSB_FIRST = 1,
    parameter int          INVERT    = 1,
    parameter logic [31:0] RST_LED   = 32'h0000_002A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spio_gen_if.slave            bus,
    output logic [LED_BITS-1:0]  led_out,
    output logic [CS_BITS-1:0]   counter_set,
    output logic [GPIO_BITS-1:0] gpio_out,
    output logic                 led_clk,
    output logic                 led_sout,
    output logic                 led_clrn,
    output logic                 led_pen
);

    localparam int                  LED_LO    = led_lo(CS_BITS);
    localparam int                  GPIO_LO   = gpio_lo(CS_BITS, LED_BITS);
    localparam logic [LED_BITS-1:0] RST_LED_W = RST_LED[LED_BITS-1:0];
    localparam logic [DATA_W-1:0]   RST_WORD  = DATA_W'(RST_LED_W) << LED_LO;

    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   word_d;
    logic [LED_BITS-1:0] led_q;
    logic [LED_BITS-1:0] led_d;
    logic [LED_BITS-1:0] snap;
    logic                trigger;
    logic                pending;
    state_t              p2s_state;

    always_comb begin
        word_d = word_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.wr_en && bus.wr_be[i]) begin
                word_d[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    assign led_q   = word_q[LED_LO +: LED_BITS];
    assign led_d   = word_d[LED_LO +: LED_BITS];
    assign trigger = bus.start | (bus.auto_en & bus.wr_en & (led_d != led_q));
    // The engine captures at the end of LOAD, so a write landing on that edge is included.
    assign snap    = (INVERT != 0) ? ~led_d : led_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= RST_WORD;
            pending  <= 1'b0;
            led_clrn <= 1'b0;
        end else begin
            word_q   <= word_d;
            led_clrn <= 1'b1;
            if (p2s_state == ST_DONE) begin
                pending <= 1'b0;
            end else if (p2s_state != ST_IDLE && trigger) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.rd_data = word_q;
    assign led_out     = led_q;
    assign counter_set = word_q[CS_BITS-1:0];
    assign gpio_out    = word_q[GPIO_LO +: GPIO_BITS];

    led_p2s_gen #(
        .LED_BITS  (LED_BITS),
        .CLK_DIV   (CLK_DIV),
        .MSB_FIRST (MSB_FIRST)
    ) u_p2s (
        .clk      (clk),
        .rst_n    (rst_n),
        .kick     (trigger | pending),
        .data     (snap),
        .state    (p2s_state),
        .busy     (bus.busy),
        .done     (bus.done),
        .led_clk  (led_clk),
        .led_sout (led_sout),
        .led_pen  (led_pen)
    );

endmodule

// File: tb/tb_spio_gen.sv
// Directed bench for spio_gen: default instance plus an 8-bit LSB-first, non-inverted, divide-by-1 instance.
module tb_spio_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spio_gen_if bus0();
    spio_gen_if bus1();

    logic [15:0] led0;
    logic [1:0]  cs0;
    logic [13:0] gpio0;
    logic        lclk0, lsout0, lclrn0, lpen0;
    logic [7:0]  led1;
    logic [1:0]  cs1;
    logic [21:0] gpio1;
    logic        lclk1, lsout1, lclrn1, lpen1;

    spio_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .led_out(led0), .counter_set(cs0), .gpio_out(gpio0),
        .led_clk(lclk0), .led_sout(lsout0), .led_clrn(lclrn0), .led_pen(lpen0)
    );

    spio_gen #(
        .LED_BITS(8), .CS_BITS(2), .GPIO_BITS(22), .CLK_DIV(1),
        .MSB_FIRST(0), .INVERT(0), .RST_LED(32'h0000_002A)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .led_out(led1), .counter_set(cs1), .gpio_out(gpio1),
        .led_clk(lclk1), .led_sout(lsout1), .led_clrn(lclrn1), .led_pen(lpen1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Chain-side observers: bits sampled on led_clk rising edges, per-cycle pulse counts.
    bit [63:0] cap0;
    int        cap0_n, pen0_n, done0_n, busy0_n;
    bit [63:0] cap1;
    int        cap1_n, done1_n;

    always @(posedge lclk0) begin
        cap0   <= {cap0[62:0], lsout0};
        cap0_n <= cap0_n + 1;
    end
    always @(posedge lclk1) begin
        cap1   <= {cap1[62:0], lsout1};
        cap1_n <= cap1_n + 1;
    end
    always @(negedge clk) begin
        if (lpen0)      pen0_n  <= pen0_n + 1;
        if (bus0.done)  done0_n <= done0_n + 1;
        if (bus0.busy)  busy0_n <= busy0_n + 1;
        if (bus1.done)  done1_n <= done1_n + 1;
    end

    typedef struct {
        logic        wr_en;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(output int n);
        n = 0;
        while (bus0.busy === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    task automatic wait_idle1(output int n);
        n = 0;
        while (bus1.busy === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    int n, b_cap, b_pen, b_done, b_busy, b_cap1, b_done1, lim;

    initial begin
        vecs[0] = '{1'b1, 4'b0010, 32'h1234_5678, 32'h0000_56A8};
        vecs[1] = '{1'b1, 4'b0001, 32'h1234_5678, 32'h0000_5678};
        vecs[2] = '{1'b1, 4'b0100, 32'hAABB_CCDD, 32'h00BB_5678};
        vecs[3] = '{1'b1, 4'b1000, 32'h1122_3344, 32'h11BB_5678};
        vecs[4] = '{1'b0, 4'b1111, 32'hFFFF_FFFF, 32'h11BB_5678};
        vecs[5] = '{1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h11BB_5678};
        vecs[6] = '{1'b1, 4'b1111, 32'hFFFC_0005, 32'hFFFC_0005};

        rst_n = 1'b0;
        bus0.wr_en = 1'b0; bus0.wr_be = 4'h0; bus0.wr_data = '0; bus0.start = 1'b0; bus0.auto_en = 1'b0;
        bus1.wr_en = 1'b0; bus1.wr_be = 4'h0; bus1.wr_data = '0; bus1.start = 1'b0; bus1.auto_en = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        #1;
        check("rst_rd", bus0.rd_data, 32'h0000_00A8);
        check("rst_led", led0, 16'h002A);
        check("rst_cs_gpio", {gpio0, cs0}, 16'h0);
        check("rst_clrn", lclrn0, 1'b0);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_lines", {lclk0, lsout0, lpen0, bus0.done}, 4'h0);
        check("rst_rd1", bus1.rd_data, 32'h0000_00A8);
        cyc();
        check("clrn_rise", lclrn0, 1'b1);

        // Register writes without any refresh trigger.
        for (int i = 0; i < 7; i++) begin
            bus0.wr_en   = vecs[i].wr_en;
            bus0.wr_be   = vecs[i].be;
            bus0.wr_data = vecs[i].data;
            cyc();
            bus0.wr_en = 1'b0;
            check($sformatf("vec%0d_rd", i), bus0.rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), led0, vecs[i].exp_rd[17:2]);
            check($sformatf("vec%0d_cs", i), cs0, vecs[i].exp_rd[1:0]);
            check($sformatf("vec%0d_gpio", i), gpio0, vecs[i].exp_rd[31:18]);
            check($sformatf("vec%0d_busy", i), bus0.busy, 1'b0);
        end

        // Single frame of ~0x0001, MSB first.
        b_cap = cap0_n; b_pen = pen0_n; b_done = done0_n;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        wait_idle0(n);
        cyc();
        check("frame_busy_cycles", n, 68);
        check("frame_nbits", cap0_n - b_cap, 16);
        check("frame_bits", cap0[15:0], 16'hFFFE);
        check("frame_pen_cycles", pen0_n - b_pen, 2);
        check("frame_done", done0_n - b_done, 1);

        // Auto refresh with two mid-frame writes and a start coalescing into one extra frame.
        b_cap = cap0_n; b_pen = pen0_n; b_done = done0_n; b_busy = busy0_n;
        bus0.auto_en = 1'b1;
        bus0.wr_en = 1'b1; bus0.wr_be = 4'hF; bus0.wr_data = 32'h0000_03FC;
        cyc();
        bus0.wr_en = 1'b0;
        check("auto_busy", bus0.busy, 1'b1);
        repeat (20) cyc();
        bus0.wr_en = 1'b1; bus0.wr_data = 32'h0000_3C3C;
        cyc();
        bus0.wr_data = 32'h0003_C3C0;
        cyc();
        bus0.wr_en = 1'b0; bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        wait_idle0(n);
        repeat (10) cyc();
        check("coal_idle", bus0.busy, 1'b0);
        check("coal_done", done0_n - b_done, 2);
        check("coal_nbits", cap0_n - b_cap, 32);
        check("coal_bits", cap0[31:0], 32'hFF00_0F0F);
        check("coal_pen_cycles", pen0_n - b_pen, 4);
        check("coal_busy_cycles", busy0_n - b_busy, 136);

        // Asynchronous reset in the middle of the shift phase.
        bus0.auto_en = 1'b0;
        b_cap = cap0_n; b_pen = pen0_n; b_done = done0_n;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        lim = 0;
        while (cap0_n - b_cap < 7 && lim < 1000) begin
            lim++;
            cyc();
        end
        check("mid_reach_bit7", cap0_n - b_cap, 7);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", bus0.busy, 1'b0);
        check("mid_lines", {lclk0, lsout0, lpen0, bus0.done, lclrn0}, 5'h0);
        check("mid_rd", bus0.rd_data, 32'h0000_00A8);
        repeat (3) cyc();
        check("mid_no_done", done0_n - b_done, 0);
        check("mid_no_pen", pen0_n - b_pen, 0);
        rst_n = 1'b1;
        cyc();
        b_cap = cap0_n; b_done = done0_n;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        wait_idle0(n);
        cyc();
        check("post_rst_busy_cycles", n, 68);
        check("post_rst_nbits", cap0_n - b_cap, 16);
        check("post_rst_bits", cap0[15:0], 16'hFFD5);
        check("post_rst_done", done0_n - b_done, 1);

        // Parametrised instance: 8 bits, LSB first, no inversion, divide by 1.
        bus1.wr_en = 1'b1; bus1.wr_be = 4'hF; bus1.wr_data = 32'h0000_0294;
        cyc();
        bus1.wr_en = 1'b0;
        check("p8_rd", bus1.rd_data, 32'h0000_0294);
        check("p8_led", led1, 8'hA5);
        check("p8_cs_gpio", {gpio1, cs1}, 24'h0);
        b_cap1 = cap1_n; b_done1 = done1_n;
        bus1.start = 1'b1;
        cyc();
        bus1.start = 1'b0;
        wait_idle1(n);
        cyc();
        check("p8_busy_cycles", n, 19);
        check("p8_nbits", cap1_n - b_cap1, 8);
        check("p8_bits_a5", cap1[7:0], 8'hA5);
        check("p8_done", done1_n - b_done1, 1);
        bus1.wr_en = 1'b1; bus1.wr_data = 32'h0000_0004;
        cyc();
        bus1.wr_en = 1'b0;
        b_cap1 = cap1_n;
        bus1.start = 1'b1;
        cyc();
        bus1.start = 1'b0;
        wait_idle1(n);
        cyc();
        check("p8_bits_01_lsb_first", cap1[7:0], 8'h80);
        check("p8_nbits2", cap1_n - b_cap1, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
